// File: rtl/mul_div_unit.sv
// RV32M multiply/divide functional unit: one-cycle 64-bit multiply, radix-2 restoring
// divide, single-cycle {rob_id, value} broadcast on the common result bus.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif

module mul_div_unit #(
  parameter int ROB_WIDTH_BIT = `ROB_WIDTH_BIT,
  parameter int DIV_STEPS     = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic                     valid,
  input  logic [2:0]               work_type,
  input  logic [31:0]              r1,
  input  logic [31:0]              r2,
  input  logic [ROB_WIDTH_BIT-1:0] inst_rob_id,
  output logic                     busy,
  output logic                     ready,
  output logic [ROB_WIDTH_BIT-1:0] rob_id,
  output logic [31:0]              value
);

  localparam int CNT_W = $clog2(DIV_STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                   state_r, state_s;
  logic [2:0]               op_r, op_s;
  logic [31:0]              quo_r, quo_s;
  logic [31:0]              dsr_r, dsr_s;
  logic [31:0]              rem_r, rem_s;
  logic [CNT_W-1:0]         cnt_r, cnt_s;
  logic                     sa_r, sa_s, sb_r, sb_s;
  logic                     negq_r, negq_s, negr_r, negr_s;
  logic                     ready_r, ready_s;
  logic [ROB_WIDTH_BIT-1:0] rob_r, rob_s;
  logic [31:0]              val_r, val_s;

  logic        sdiv_s, div_zero_s, div_ovf_s;
  logic [63:0] ma_s, mb_s, prod_s;
  logic [31:0] mul_res_s, q_res_s, r_res_s;
  logic [32:0] shift_s, diff_s;

  // Absolute value of an operand when it is interpreted as signed.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  assign sdiv_s     = work_type[2] & ~work_type[0];
  assign div_zero_s = (r2 == 32'd0);
  assign div_ovf_s  = sdiv_s && (r1 == 32'h8000_0000) && (r2 == 32'hFFFF_FFFF);

  // Modulo-2^64 product of sign/zero-extended operands equals the exact 33x33 product.
  assign ma_s      = {{32{sa_r & quo_r[31]}}, quo_r};
  assign mb_s      = {{32{sb_r & dsr_r[31]}}, dsr_r};
  assign prod_s    = ma_s * mb_s;
  assign mul_res_s = (op_r == 3'd0) ? prod_s[31:0] : prod_s[63:32];

  assign shift_s = {rem_r, quo_r[31]};
  assign diff_s  = shift_s - {1'b0, dsr_r};
  assign q_res_s = negq_r ? (32'd0 - quo_r) : quo_r;
  assign r_res_s = negr_r ? (32'd0 - rem_r) : rem_r;

  // Next-state and datapath update for the issue/compute/broadcast sequence.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    quo_s   = quo_r;
    dsr_s   = dsr_r;
    rem_s   = rem_r;
    cnt_s   = cnt_r;
    sa_s    = sa_r;
    sb_s    = sb_r;
    negq_s  = negq_r;
    negr_s  = negr_r;
    rob_s   = rob_r;
    val_s   = val_r;
    ready_s = 1'b0;
    if (clear) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid) begin
            op_s   = work_type;
            rob_s  = inst_rob_id;
            sa_s   = (work_type == 3'd1) || (work_type == 3'd2);
            sb_s   = (work_type == 3'd1);
            negq_s = sdiv_s & (r1[31] ^ r2[31]);
            negr_s = sdiv_s & r1[31];
            rem_s  = 32'd0;
            cnt_s  = CNT_INIT;
            if (!work_type[2]) begin
              quo_s   = r1;
              dsr_s   = r2;
              state_s = ST_MUL;
            end else if (div_zero_s) begin
              val_s   = work_type[1] ? r1 : 32'hFFFF_FFFF;
              state_s = ST_DONE;
            end else if (div_ovf_s) begin
              val_s   = work_type[1] ? 32'd0 : 32'h8000_0000;
              state_s = ST_DONE;
            end else begin
              quo_s   = mag(r1, sdiv_s);
              dsr_s   = mag(r2, sdiv_s);
              state_s = ST_DIV;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          val_s   = mul_res_s;
          state_s = ST_DONE;
        end
        ST_DIV: begin
          if (cnt_r != CNT_ZERO) begin
            // Dividend shifts out of quo_r while quotient bits shift in.
            if (!diff_s[32]) begin
              rem_s = diff_s[31:0];
              quo_s = {quo_r[30:0], 1'b1};
            end else begin
              rem_s = shift_s[31:0];
              quo_s = {quo_r[30:0], 1'b0};
            end
            cnt_s = cnt_r - CNT_ONE;
          end else begin
            val_s   = op_r[1] ? r_res_s : q_res_s;
            state_s = ST_DONE;
          end
        end
        ST_DONE: begin
          ready_s = 1'b1;
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers: reset dominates, a low rdy_in freezes everything.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
      op_r    <= 3'd0;
      quo_r   <= 32'd0;
      dsr_r   <= 32'd0;
      rem_r   <= 32'd0;
      cnt_r   <= CNT_ZERO;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      negq_r  <= 1'b0;
      negr_r  <= 1'b0;
      ready_r <= 1'b0;
      rob_r   <= '0;
      val_r   <= 32'd0;
    end else if (rdy_in) begin
      state_r <= state_s;
      op_r    <= op_s;
      quo_r   <= quo_s;
      dsr_r   <= dsr_s;
      rem_r   <= rem_s;
      cnt_r   <= cnt_s;
      sa_r    <= sa_s;
      sb_r    <= sb_s;
      negq_r  <= negq_s;
      negr_r  <= negr_s;
      ready_r <= ready_s;
      rob_r   <= rob_s;
      val_r   <= val_s;
    end
  end

  assign busy   = (state_r != ST_IDLE);
  assign ready  = ready_r;
  assign rob_id = rob_r;
  assign value  = val_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed test-plan cases plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_mul_div_unit;
  localparam int RW = 4;
  localparam int STEPS = 32;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          rdy_in = 1'b1;
  logic          clear = 1'b0;
  logic          valid = 1'b0;
  logic [2:0]    work_type = 3'd0;
  logic [31:0]   r1 = 32'd0;
  logic [31:0]   r2 = 32'd0;
  logic [RW-1:0] inst_rob_id = '0;
  logic          busy, ready;
  logic [RW-1:0] rob_id;
  logic [31:0]   value;

  int errors = 0;
  int checks = 0;
  int ncyc = 0;

  mul_div_unit #(.ROB_WIDTH_BIT(RW), .DIV_STEPS(STEPS)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .valid(valid),
    .work_type(work_type), .r1(r1), .r2(r2), .inst_rob_id(inst_rob_id),
    .busy(busy), .ready(ready), .rob_id(rob_id), .value(value)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of an RV32M op.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0, 3'd1: p = sa * sb;
      3'd2:       p = sa * longint'({32'h0, b});
      3'd3:       p = {32'h0, a} * {32'h0, b};
      default:    p = 64'h0;
    endcase
    if (op == 3'd0) return p[31:0];
    if (op < 3'd4) return p[63:32];
    if (b == 32'd0) return (op == 3'd6 || op == 3'd7) ? a : 32'hFFFF_FFFF;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == 3'd6) ? 32'd0 : 32'h8000_0000;
    case (op)
      3'd4:    return ia / ib;
      3'd5:    return a / b;
      3'd6:    return ia % ib;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op < 3'd4) return 2;
    if (b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return STEPS + 2;
  endfunction

  // Reference model: one pending op with a remaining-edge count.
  logic          m_ready = 1'b0;
  logic          m_pend = 1'b0;
  logic [31:0]   m_val = 32'd0;
  logic [RW-1:0] m_tag = '0;
  logic [31:0]   p_val = 32'd0;
  logic [RW-1:0] p_tag = '0;
  int            m_left = 0;

  always @(posedge clk_in) begin
    if (!rst_in) begin
      m_ready <= 1'b0;
      m_pend  <= 1'b0;
      m_left  <= 0;
      m_val   <= 32'd0;
      m_tag   <= '0;
    end else if (rdy_in) begin
      m_ready <= 1'b0;
      if (clear) begin
        m_pend <= 1'b0;
      end else if (m_pend) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_pend  <= 1'b0;
          m_ready <= 1'b1;
          m_val   <= p_val;
          m_tag   <= p_tag;
        end
      end else if (valid) begin
        m_pend <= 1'b1;
        m_left <= ref_latency(work_type, r1, r2);
        p_val  <= ref_result(work_type, r1, r2);
        p_tag  <= inst_rob_id;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_in) begin
    chk("busy", {31'd0, busy}, {31'd0, m_pend});
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    if (m_ready) begin
      chk("value", value, m_val);
      chk("rob_id", {28'd0, rob_id}, {28'd0, m_tag});
    end
  end

  task automatic step();
    @(negedge clk_in);
    ncyc++;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [RW-1:0] tag);
    valid = 1'b1;
    work_type = op;
    r1 = a;
    r2 = b;
    inst_rob_id = tag;
    @(negedge clk_in);
    valid = 1'b0;
    ncyc = 0;
  endtask

  task automatic wait_pulse(input string name, input logic [31:0] exp_val,
                            input logic [RW-1:0] exp_tag, input int exp_lat);
    while (!ready && ncyc < 300) step();
    chk({name, " latency"}, ncyc, exp_lat);
    chk({name, " value"}, value, exp_val);
    chk({name, " rob_id"}, {28'd0, rob_id}, {28'd0, exp_tag});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk_in);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset ready", {31'd0, ready}, 32'd0);
    chk("reset value", value, 32'd0);
    chk("reset rob_id", {28'd0, rob_id}, 32'd0);
    rst_in = 1'b1;
    @(negedge clk_in);

    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 4'd5); wait_pulse("MUL", 32'hFFFF_FFFE, 4'd5, 2);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 4'd6); wait_pulse("MULH", 32'hFFFF_FFFF, 4'd6, 2);
    issue(3'd3, 32'hFFFF_FFFF, 32'd2, 4'd7); wait_pulse("MULHU", 32'h0000_0001, 4'd7, 2);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 4'd8); wait_pulse("MULHSU", 32'hFFFF_FFFF, 4'd8, 2);

    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd1); wait_pulse("DIV", 32'hFFFF_FFFD, 4'd1, 34);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 4'd2); wait_pulse("REM", 32'hFFFF_FFFF, 4'd2, 34);
    issue(3'd5, 32'd100, 32'd7, 4'd3);       wait_pulse("DIVU", 32'd14, 4'd3, 34);
    issue(3'd7, 32'd100, 32'd7, 4'd4);       wait_pulse("REMU", 32'd2, 4'd4, 34);

    issue(3'd5, 32'd55, 32'd0, 4'd9);                   wait_pulse("DIVU/0", 32'hFFFF_FFFF, 4'd9, 1);
    issue(3'd6, 32'd13, 32'd0, 4'd10);                  wait_pulse("REM/0", 32'd13, 4'd10, 1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11);   wait_pulse("DIV ovf", 32'h8000_0000, 4'd11, 1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12);   wait_pulse("REM ovf", 32'd0, 4'd12, 1);

    // Flush at T+10, then a new MUL the next cycle.
    issue(3'd4, 32'd1000, 32'd3, 4'd2);
    repeat (9) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    chk("flush ready", {31'd0, ready}, 32'd0);
    issue(3'd0, 32'd3, 32'd4, 4'd13); wait_pulse("MUL after flush", 32'd12, 4'd13, 2);

    // Pause 5 cycles mid-divide, then valid while busy.
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd3);
    repeat (5) step();
    rdy_in = 1'b0;
    repeat (5) step();
    rdy_in = 1'b1;
    valid = 1'b1; work_type = 3'd0; r1 = 32'd9; r2 = 32'd9; inst_rob_id = 4'd14;
    repeat (2) step();
    valid = 1'b0;
    wait_pulse("DIV paused", 32'hFFFF_FFFD, 4'd3, 39);

    // Reset mid-divide.
    issue(3'd5, 32'd12345, 32'd17, 4'd6);
    repeat (10) step();
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst ready", {31'd0, ready}, 32'd0);
    chk("rst value", value, 32'd0);
    chk("rst rob_id", {28'd0, rob_id}, 32'd0);
    issue(3'd0, 32'd7, 32'd6, 4'd15); wait_pulse("MUL after reset", 32'd42, 4'd15, 2);

    // Randomized traffic checked by the per-cycle model comparison.
    for (int i = 0; i < 4000; i++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 59) == 0);
      valid = ($urandom_range(0, 2) != 0);
      work_type = 3'($urandom_range(0, 7));
      r1 = pick();
      r2 = pick();
      inst_rob_id = RW'($urandom_range(0, 15));
      @(negedge clk_in);
    end
    valid = 1'b0;
    clear = 1'b0;
    rdy_in = 1'b1;
    repeat (40) @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle RV32M functional unit.
- Sits downstream of the reservation station, in parallel with the scalar ALU. It accepts one ready-operand instruction at a time, computes multiply or divide/remainder, and broadcasts {rob_id, value} for one cycle on the common result bus (to the ROB and to RS/LSB wakeup).
- Exposes busy so the reservation station holds M-type entries while the unit is occupied.

Parameters:
- ROB_WIDTH_BIT, default `ROB_WIDTH_BIT: width of ROB tag.
- DIV_STEPS, default 32: quotient bits produced by the radix-2 divider (fixed at 32 for RV32).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-low
- rdy_in  input  1  global pause; when low, all state is frozen
- clear  input  1  misprediction flush; abort in-flight op
- valid  input  1  issue strobe from the reservation station
- work_type  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- r1  input  32  rs1 value
- r2  input  32  rs2 value
- inst_rob_id  input  ROB_WIDTH_BIT  tag of the issued instruction
- busy  output  1  unit occupied; issue not permitted
- ready  output  1  result valid pulse (registered)
- rob_id  output  ROB_WIDTH_BIT  tag of the result
- value  output  32  result data

Behaviour:
- Reset (rst_in==0 at posedge, dominates everything):
  - state=IDLE; busy=0, ready=0, rob_id=0, value=0.
  - All internal registers cleared.
- Pause: if rst_in==1 and rdy_in==0, nothing changes, including ready/value. A pulse is held and the consumer is likewise paused.
- FSM states:
  - IDLE, MUL, DIV, DONE.
  - busy = (state != IDLE).
- Accept occurs when state==IDLE && valid && !clear. At accept, latch op, rob_id, r1, r2, and sign info.
  - type<4 goes to MUL.
  - type>=4 with r2==0 or signed overflow (type 4/6, r1=0x80000000, r2=0xFFFFFFFF) goes to DONE directly with the special result.
  - Otherwise goes to DIV with counter=DIV_STEPS.
- valid while busy: protocol violation. The op is ignored and state is unaffected.
- MUL (1 cycle):
  - Compute the 64-bit product of sign/zero-extended 33-bit operands.
  - MUL takes the low 32 bits. MULH, MULHSU and MULHU take the high 32 bits; MULHSU treats rs1 as signed and rs2 as unsigned.
  - Register the result into value and go to DONE.
- DIV:
  - Restoring radix-2 division on magnitudes (|r1|, |r2| for signed ops), one quotient bit per cycle.
  - The counter decrements each cycle. When it reaches 0, apply signs: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into value, then go to DONE.
- Special results:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give r1.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- DONE:
  - ready=1 for exactly one cycle, with rob_id and value valid. Next state is IDLE.
  - ready is 0 in all other states.
  - No new accept is possible in the DONE cycle; the earliest next accept is the cycle after the pulse.
- Latency (accept edge T):
  - MUL ops pulse ready at edge T+2.
  - Special-case divides pulse at T+1.
  - Normal divides pulse at T+DIV_STEPS+2 (T+34).
- Throughput: one op per (latency+1) cycles.
- clear (with rst_in==1 and rdy_in==1) forces IDLE and ready=0 on the next edge from any state, including DONE. The in-flight result is discarded, and any valid in the same cycle is dropped.
- Widths: all arithmetic is 32-bit modulo. The internal remainder is 33 bits for the restoring subtract; the product is 64 bits.

Test Plan:
- MUL/MULH: MUL r1=0xFFFFFFFF, r2=2, tag 5 -> ready at T+2 with value=0xFFFFFFFE, rob_id=5. MULH with the same operands -> 0xFFFFFFFF. MULHU -> 0x00000001. MULHSU -> 0xFFFFFFFF.
- Signed divide: DIV r1=-7 (0xFFFFFFF9), r2=2 -> value=0xFFFFFFFD at T+34, busy high T+1..T+34. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU -> 2.
- Corner cases: DIVU r2=0 -> 0xFFFFFFFF at T+1. REM 13/0 -> 13. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. Each gives a single ready pulse.
- Flush mid-op: start DIV, assert clear at T+10 -> busy=0 and ready never pulses. A new MUL 3*4 issued the next cycle -> 12 at +2 with the new tag.
- Pause and back-pressure: hold rdy_in low for 5 cycles during DIV -> pulse delayed by exactly 5 cycles with the same value. valid asserted while busy -> no change to result or tag.
- Reset: drive rst_in low during DIV for one edge -> busy=0, ready=0, value=0, rob_id=0. A subsequent op completes normally.
